edge_detect_multi: RTL and testbench

EDGE_DETECT_MULTI -- requirements
Module: edge_detect_multi

---
 rtl/edge_detect_multi.sv | 106 ++++++++++
 tb/tb_edge_detect_multi.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_multi.sv
`default_nettype none
// ============================================================================
//  Module      : edge_detect_multi
//  Description : N-channel edge detector. Each channel synchronizes an
//                asynchronous level input and runs a small Moore FSM that
//                visits RISE or FALL once per synchronized transition.
//                The per-channel mode bits select which visits raise tick.
//                Each channel also keeps a saturating edge counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_detect_multi #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       level,
    input  logic [2*N-1:0]     mode,
    input  logic [N-1:0]       clr,
    output logic [N-1:0]       level_sync,
    output logic [N-1:0]       tick,
    output logic               any_tick,
    output logic [N*CNT_W-1:0] cnt
);

    // Per-channel FSM encoding
    localparam logic [1:0] c_ZERO = 2'd0;
    localparam logic [1:0] c_RISE = 2'd1;
    localparam logic [1:0] c_ONE  = 2'd2;
    localparam logic [1:0] c_FALL = 2'd3;

    // Counter saturation value
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [1:0]             r_state;
        logic [1:0]             w_next;
        logic                   w_s;
        logic                   w_tick;
        logic [CNT_W-1:0]       r_cnt;

        // Synchronizer chain: stage 0 captures the raw level, last stage is s
        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], level[gi]};
            end
        end

        assign w_s            = r_sync[SYNC_STAGES-1];
        assign level_sync[gi] = w_s;

        // State register
        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= c_ZERO;
            end else begin
                r_state <= w_next;
            end
        end

        // Next state: every change of s lands in RISE or FALL for one cycle,
        // even when it immediately follows the opposite transition
        always_comb begin
            w_next = r_state;
            case (r_state)
                c_ZERO:  w_next = w_s ? c_RISE : c_ZERO;
                c_RISE:  w_next = w_s ? c_ONE  : c_FALL;
                c_ONE:   w_next = w_s ? c_ONE  : c_FALL;
                c_FALL:  w_next = w_s ? c_RISE : c_ZERO;
                default: w_next = c_ZERO;
            endcase
        end

        // Output: mode only gates which visits pulse, never the transitions
        always_comb begin
            w_tick = 1'b0;
            if ((r_state == c_RISE) && mode[2*gi])
                w_tick = 1'b1;
            if ((r_state == c_FALL) && mode[2*gi+1])
                w_tick = 1'b1;
        end

        assign tick[gi] = w_tick;

        // Saturating edge counter; clear takes priority over a same-cycle tick
        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (clr[gi]) begin
                r_cnt <= '0;
            end else if (w_tick && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign cnt[gi*CNT_W +: CNT_W] = r_cnt;
    end

    assign any_tick = |tick;

endmodule
`default_nettype wire

// File: tb/tb_edge_detect_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_edge_detect_multi
//  Description : Directed self-checking bench for edge_detect_multi. A
//                default-sized instance and a CNT_W=2 instance share stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_detect_multi;

    localparam int N  = 4;
    localparam int SS = 2;

    logic         clk;
    logic         reset;
    logic [3:0]   level;
    logic [7:0]   mode;
    logic [3:0]   clr;
    logic [3:0]   level_sync, level_sync_s;
    logic [3:0]   tick, tick_s;
    logic         any_tick, any_tick_s;
    logic [31:0]  cnt;
    logic [7:0]   cnt_s;

    int checks = 0;
    int errors = 0;
    int tcount;

    edge_detect_multi #(.N(N), .SYNC_STAGES(SS), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .level      (level),
        .mode       (mode),
        .clr        (clr),
        .level_sync (level_sync),
        .tick       (tick),
        .any_tick   (any_tick),
        .cnt        (cnt)
    );

    edge_detect_multi #(.N(N), .SYNC_STAGES(SS), .CNT_W(2)) dut_s (
        .clk        (clk),
        .reset      (reset),
        .level      (level),
        .mode       (mode),
        .clr        (clr),
        .level_sync (level_sync_s),
        .tick       (tick_s),
        .any_tick   (any_tick_s),
        .cnt        (cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        level = 4'h0;
        mode  = 8'hFF;
        clr   = 4'h0;

        // Reset state
        step(); step(); step();
        chk("rst_sync", {28'd0, level_sync}, 32'h0);
        chk("rst_tick", {28'd0, tick}, 32'h0);
        chk("rst_any",  {31'd0, any_tick}, 32'h0);
        chk("rst_cnt",  cnt, 32'h0);
        chk("rst_cnt_s", {24'd0, cnt_s}, 32'h0);

        reset = 1'b0;
        step();
        chk("post_rst_quiet", {24'd0, level_sync, tick}, 32'h0);

        // Latency: rise captured at E0, tick only after E0+2
        level = 4'b0001;
        step();
        chk("lat_e0", {24'd0, level_sync, tick}, 32'h0);
        step();
        chk("lat_e1_sync", {28'd0, level_sync}, 32'h1);
        chk("lat_e1_tick", {28'd0, tick}, 32'h0);
        step();
        chk("lat_e2_tick", {28'd0, tick}, 32'h1);
        chk("lat_e2_any",  {31'd0, any_tick}, 32'h1);
        step();
        chk("lat_e3_tick", {28'd0, tick}, 32'h0);
        chk("lat_cnt",     cnt, 32'h0000_0001);
        chk("lat_cnt_s",   {24'd0, cnt_s}, 32'h01);

        // Fall on channel 0 with both directions enabled
        level = 4'b0000;
        step(); step(); step();
        chk("fall_tick", {28'd0, tick}, 32'h1);
        step();
        chk("fall_cnt", cnt, 32'h0000_0002);

        // Rise-only mode over a 5-cycle pulse; mode acts combinationally
        mode[1:0] = 2'b01;
        level[0] = 1'b1;
        step(); step(); step();
        chk("m01_rise", {28'd0, tick}, 32'h1);
        step(); step();
        level[0] = 1'b0;
        step(); step(); step();
        chk("m01_fall_masked", {28'd0, tick}, 32'h0);
        mode[1:0] = 2'b11;
        #1;
        chk("mode_comb_on", {27'd0, any_tick, tick}, 32'h11);
        mode[1:0] = 2'b01;
        #1;
        chk("mode_comb_off", {27'd0, any_tick, tick}, 32'h00);
        step();
        chk("m01_cnt", cnt, 32'h0000_0003);

        // Fall-only mode
        mode[1:0] = 2'b10;
        level[0] = 1'b1;
        step(); step(); step();
        chk("m10_rise_masked", {28'd0, tick}, 32'h0);
        step(); step();
        level[0] = 1'b0;
        step(); step(); step();
        chk("m10_fall", {28'd0, tick}, 32'h1);
        step();
        chk("m10_cnt", cnt, 32'h0000_0004);
        mode = 8'hFF;

        // Six edges on channel 1: 2-bit counter saturates at 3
        tcount = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 6) level[1] = ~level[1];
            step();
            tcount += int'(tick_s[1]);
        end
        chk("sat_ticks", tcount, 32'd6);
        chk("sat_cnt_s1", {30'd0, cnt_s[3:2]}, 32'd3);
        chk("sat_cnt_big1", {24'd0, cnt[15:8]}, 32'd6);

        // Clear wins over a same-cycle tick on channel 2
        for (int i = 0; i < 8; i++) begin
            if (i < 6) level[2] = ~level[2];
            step();
        end
        chk("clr_pre_tick", {31'd0, tick[2]}, 32'd1);
        chk("clr_pre_cnt",  {24'd0, cnt[23:16]}, 32'd5);
        clr[2] = 1'b1;
        step();
        clr[2] = 1'b0;
        chk("clr_cnt", {24'd0, cnt[23:16]}, 32'd0);
        step();
        chk("clr_hold", {24'd0, cnt[23:16]}, 32'd0);

        // Channel 3 toggles every cycle: tick every cycle once in the pipe
        tcount = 0;
        for (int i = 1; i <= 12; i++) begin
            level[3] = ~level[3];
            step();
            if (i >= 3) tcount += int'(tick[3]);
        end
        chk("tog_ticks", tcount, 32'd10);
        chk("tog_cnt_mid", {24'd0, cnt[31:24]}, 32'd9);
        step(); step(); step(); step();
        chk("tog_cnt_end", {24'd0, cnt[31:24]}, 32'd12);
        chk("tog_other", cnt[23:0], 32'h00_06_04);

        // Reset mid-visit abandons the pending tick
        level[0] = 1'b1;
        step(); step(); step();
        chk("mid_pre", {28'd0, tick}, 32'h1);
        reset = 1'b1;
        step();
        chk("mid_tick", {27'd0, any_tick, tick}, 32'h0);
        chk("mid_cnt",  cnt, 32'h0);
        chk("mid_sync", {28'd0, level_sync}, 32'h0);

        // Levels held high through reset release count as rises
        level = 4'hF;
        step();
        reset = 1'b0;
        step();
        chk("rel_e1", {24'd0, level_sync, tick}, 32'h0);
        step();
        chk("rel_e2_sync", {28'd0, level_sync}, 32'hF);
        chk("rel_e2_tick", {28'd0, tick}, 32'h0);
        step();
        chk("rel_e3_tick", {27'd0, any_tick, tick}, 32'h1F);
        step();
        chk("rel_after", {27'd0, any_tick, tick}, 32'h0);
        chk("rel_cnt",   cnt, 32'h0101_0101);
        chk("rel_cnt_s", {24'd0, cnt_s}, 32'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
